// File: rtl/w5300_access_arbiter.sv
// Round-robin arbiter sharing one W5300 bus interface among NUM_REQ requesters.
// Keeps a side-effect-free dummy read on the bus whenever no real access is armed.
module w5300_access_arbiter #(
   parameter int         NUM_REQ        = 2,
   parameter logic [9:0] IDLE_ADDR      = 10'h000,
   parameter int         TIMEOUT_CYCLES = 1024
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req,
   input  logic [NUM_REQ-1:0]      req_wr,
   input  logic [NUM_REQ*10-1:0]   req_addr,
   input  logic [NUM_REQ*16-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]      gnt,
   output logic [NUM_REQ-1:0]      done,
   output logic [15:0]             rd_data,
   output logic                    err,
   output logic                    bus_ready,
   output logic [10:0]             bus_ctrl_addr,
   output logic [15:0]             bus_wr_data,
   input  logic [15:0]             bus_rd_data,
   input  logic                    bus_op_idle
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

   typedef enum logic [1:0] {IDLE, ARM, BUSY} state_t;

   state_t        state, state_nxt;
   logic [PW-1:0] rr_ptr, win, win_idx;
   logic          found;
   logic [CW-1:0] tmo_cnt;
   logic          timeout;
   logic          sel_wr;
   logic [9:0]    sel_addr;
   logic [15:0]   sel_wdata;
   logic          lat_wr;
   logic [9:0]    lat_addr;
   logic [15:0]   lat_wdata;

   // Search order starts one past the last winner, so nobody waits more than NUM_REQ-1 accesses.
   always_comb begin
      found     = 1'b0;
      win       = rr_ptr;
      sel_wr    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && req[j] && (j == (int'(rr_ptr) + k) % NUM_REQ)) begin
               found = 1'b1;
               win   = PW'(j);
            end
         end
      end
      for (int j = 0; j < NUM_REQ; j++) begin
         if (PW'(j) == win) begin
            sel_wr    = req_wr[j];
            sel_addr  = req_addr[10*j +: 10];
            sel_wdata = req_wdata[16*j +: 16];
         end
      end
   end

   assign timeout = (tmo_cnt >= CW'(TIMEOUT_CYCLES - 1));

   // A launch in ARM wins over a simultaneous timeout: the bus has already taken the real address.
   always_comb begin
      state_nxt     = state;
      bus_ctrl_addr = {1'b0, IDLE_ADDR};
      bus_wr_data   = '0;
      case (state)
         IDLE: begin
            if (bus_ready && found && !(|done)) state_nxt = ARM;
         end
         ARM: begin
            bus_ctrl_addr = {lat_wr, lat_addr};
            bus_wr_data   = lat_wdata;
            if (bus_op_idle)  state_nxt = BUSY;
            else if (timeout) state_nxt = IDLE;
         end
         BUSY: begin
            if (bus_op_idle || timeout) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rr_ptr    <= PW'(NUM_REQ - 1);
         win_idx   <= '0;
         gnt       <= '0;
         done      <= '0;
         err       <= 1'b0;
         rd_data   <= '0;
         bus_ready <= 1'b0;
         tmo_cnt   <= '0;
      end else begin
         state <= state_nxt;
         done  <= '0;
         err   <= 1'b0;
         if (bus_op_idle) bus_ready <= 1'b1;
         if (|done)       gnt       <= '0;
         case (state)
            IDLE: begin
               if (state_nxt == ARM) begin
                  gnt     <= NUM_REQ'(1) << win;
                  rr_ptr  <= win;
                  win_idx <= win;
                  tmo_cnt <= '0;
               end
            end
            ARM, BUSY: begin
               tmo_cnt <= tmo_cnt + CW'(1);
               if (state_nxt == IDLE) begin
                  done <= NUM_REQ'(1) << win_idx;
                  err  <= !(state == BUSY && bus_op_idle);
                  if (state == BUSY && bus_op_idle && !lat_wr) rd_data <= bus_rd_data;
               end
            end
            default: ;
         endcase
      end
   end

   // Access fields are only meaningful while granted, so they carry no reset.
   always_ff @(posedge clk) begin
      if (state == IDLE && state_nxt == ARM) begin
         lat_wr    <= sel_wr;
         lat_addr  <= sel_addr;
         lat_wdata <= sel_wdata;
      end
   end

endmodule

// File: tb/tb_w5300_access_arbiter.sv
// Directed bench for w5300_access_arbiter with a free-running W5300 bus-interface model.
module tb_w5300_access_arbiter;

   localparam int N   = 2;
   localparam int TMO = 16;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req, req_wr;
   logic [N*10-1:0] req_addr;
   logic [N*16-1:0] req_wdata;
   logic [N-1:0]    gnt, done;
   logic [15:0]     rd_data;
   logic            err, bus_ready;
   logic [10:0]     bus_ctrl_addr;
   logic [15:0]     bus_wr_data, bus_rd_data;
   logic            bus_op_idle;

   w5300_access_arbiter #(.NUM_REQ(N), .IDLE_ADDR(10'h000), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_wr(req_wr), .req_addr(req_addr),
      .req_wdata(req_wdata), .gnt(gnt), .done(done), .rd_data(rd_data), .err(err),
      .bus_ready(bus_ready), .bus_ctrl_addr(bus_ctrl_addr), .bus_wr_data(bus_wr_data),
      .bus_rd_data(bus_rd_data), .bus_op_idle(bus_op_idle)
   );

   always #5 clk = ~clk;

   int n_tests = 0, n_fail = 0, cyc = 0;
   bit bus_en = 1'b0;
   int n_real = 0, n_ops = 0;
   logic [10:0] last_real = '0, last_any = '0;
   logic [15:0] last_wd = '0;

   always @(posedge clk) cyc++;

   // Bus model: one idle cycle, then three busy cycles, repeating while enabled.
   initial begin
      int cnt;
      cnt = 0;
      bus_op_idle = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (!bus_en) bus_op_idle = 1'b0;
         else if (cnt == 0) begin bus_op_idle = 1'b1; cnt = 3; end
         else begin bus_op_idle = 1'b0; cnt--; end
      end
   end

   always @(negedge clk) begin
      if (bus_op_idle) begin
         n_ops++;
         last_any = bus_ctrl_addr;
         if (bus_ctrl_addr != 11'h000) begin
            n_real++;
            last_real = bus_ctrl_addr;
            last_wd   = bus_wr_data;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_req(input int r, input bit wr, input logic [9:0] a, input logic [15:0] d);
      req_wr[r]          = wr;
      req_addr[r*10+:10] = a;
      req_wdata[r*16+:16] = d;
      req[r]             = 1'b1;
   endtask

   // Waits for done; also kills the bus right after a real launch when kill_after_launch is set.
   task automatic wait_done(input int limit, input bit kill_after_launch,
                            output int dcyc, output logic [N-1:0] fg, output int gcyc);
      int nr0;
      nr0  = n_real;
      fg   = '0;
      gcyc = -1;
      dcyc = -1;
      for (int i = 0; i < limit; i++) begin
         @(posedge clk);
         #1;
         if (fg == '0 && gnt != '0) begin fg = gnt; gcyc = cyc; end
         if (kill_after_launch && n_real != nr0) bus_en = 1'b0;
         if (done != '0) begin dcyc = cyc; return; end
      end
      n_tests++;
      n_fail++;
      $display("FAIL wait_done: no done within %0d cycles", limit);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      int          r;
      bit          wr;
      logic [9:0]  addr;
      logic [15:0] wdata;
      logic [15:0] brd;
      logic [15:0] exp_rd;
      logic [10:0] exp_ctrl;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int dcyc, gcyc, nr0, gnt_early;
      logic [N-1:0] fg;
      vecs[0] = '{1, 1'b0, 10'h202, 16'hDEAD, 16'hA5C3, 16'hA5C3, 11'h202};
      vecs[1] = '{0, 1'b1, 10'h22E, 16'h1234, 16'hFFFF, 16'hA5C3, 11'h62E};
      vecs[2] = '{0, 1'b0, 10'h3FF, 16'h0000, 16'h0001, 16'h0001, 11'h3FF};
      vecs[3] = '{1, 1'b1, 10'h001, 16'hFFFF, 16'h7777, 16'h0001, 11'h401};
      vecs[4] = '{1, 1'b0, 10'h100, 16'hBEEF, 16'h8000, 16'h8000, 11'h100};

      rst_n = 1'b0; req = '0; req_wr = '0; req_addr = '0; req_wdata = '0; bus_rd_data = '0;
      repeat (3) tick();
      check("rst_gnt", gnt, 0);
      check("rst_done", done, 0);
      check("rst_rd_data", rd_data, 0);
      check("rst_err", err, 0);
      check("rst_bus_ready", bus_ready, 0);
      check("rst_bus_ctrl", bus_ctrl_addr, 11'h000);

      // Request held off until the bus interface leaves reset
      set_req(0, 1'b0, 10'h005, 16'h0000);
      rst_n = 1'b1;
      gnt_early = 0;
      repeat (100) begin tick(); if (gnt != '0) gnt_early++; end
      check("gnt_before_ready", gnt_early, 0);
      check("ready_low_before_idle", bus_ready, 0);
      bus_en = 1'b1;
      bus_rd_data = 16'h0BEE;
      tick();
      check("ready_after_first_idle", bus_ready, 1);
      wait_done(100, 1'b0, dcyc, fg, gcyc);
      check("first_done", done, 2'b01);
      check("first_rd", rd_data, 16'h0BEE);
      req = '0;
      tick();

      for (int i = 0; i < 5; i++) begin
         bus_rd_data = vecs[i].brd;
         nr0 = n_real;
         set_req(vecs[i].r, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
         wait_done(100, 1'b0, dcyc, fg, gcyc);
         check($sformatf("v%0d_done", i), done, N'(1) << vecs[i].r);
         check($sformatf("v%0d_gnt", i), fg, N'(1) << vecs[i].r);
         check($sformatf("v%0d_err", i), err, 0);
         check($sformatf("v%0d_rd", i), rd_data, vecs[i].exp_rd);
         check($sformatf("v%0d_nreal", i), n_real - nr0, 1);
         check($sformatf("v%0d_ctrl", i), last_real, vecs[i].exp_ctrl);
         check($sformatf("v%0d_wd", i), last_wd, vecs[i].wdata);
         check($sformatf("v%0d_dummy_at_done", i), last_any, 11'h000);
         req[vecs[i].r] = 1'b0;
         tick();
         check($sformatf("v%0d_done_pulse", i), done, 0);
         check($sformatf("v%0d_gnt_drop", i), gnt, 0);
      end

      // Both requesters hammering: grants must alternate starting with 0
      set_req(0, 1'b0, 10'h010, 16'h0000);
      set_req(1, 1'b0, 10'h020, 16'h0000);
      for (int k = 0; k < 8; k++) begin
         wait_done(100, 1'b0, dcyc, fg, gcyc);
         check($sformatf("fair%0d", k), done, (k % 2 == 0) ? 2'b01 : 2'b10);
         req = '0;
         tick();
         req = 2'b11;
      end
      req = '0;
      tick();

      // Timeout after launch: rd_data keeps 16'h8000 from the fairness reads
      bus_rd_data = 16'h5555;
      nr0 = n_real;
      set_req(0, 1'b0, 10'h030, 16'h0000);
      wait_done(100, 1'b1, dcyc, fg, gcyc);
      check("tmo_busy_done", done, 2'b01);
      check("tmo_busy_err", err, 1);
      check("tmo_busy_rd_kept", rd_data, 16'h8000);
      check("tmo_busy_latency", dcyc - gcyc, TMO);
      check("tmo_busy_launched", n_real - nr0, 1);
      req = '0;
      tick();
      check("tmo_err_pulse", err, 0);

      // Timeout while still armed: access never reaches the bus
      nr0 = n_real;
      set_req(1, 1'b1, 10'h040, 16'hCAFE);
      wait_done(100, 1'b0, dcyc, fg, gcyc);
      check("tmo_arm_done", done, 2'b10);
      check("tmo_arm_err", err, 1);
      check("tmo_arm_latency", dcyc - gcyc, TMO);
      check("tmo_arm_not_launched", n_real - nr0, 0);
      req = '0;
      tick();

      bus_en = 1'b1;
      bus_rd_data = 16'h1357;
      set_req(0, 1'b0, 10'h050, 16'h0000);
      wait_done(100, 1'b0, dcyc, fg, gcyc);
      check("recover_done", done, 2'b01);
      check("recover_err", err, 0);
      check("recover_rd", rd_data, 16'h1357);
      req = '0;
      tick();

      // Reset while BUSY
      nr0 = n_real;
      set_req(1, 1'b0, 10'h060, 16'h0000);
      for (int i = 0; i < 100 && n_real == nr0; i++) tick();
      check("busy_reached", n_real - nr0, 1);
      rst_n = 1'b0;
      #1;
      check("arst_gnt", gnt, 0);
      check("arst_done", done, 0);
      check("arst_err", err, 0);
      check("arst_rd", rd_data, 0);
      check("arst_ready", bus_ready, 0);
      req = '0;
      tick();
      rst_n = 1'b1;
      bus_rd_data = 16'h2468;
      set_req(0, 1'b0, 10'h070, 16'h0000);
      set_req(1, 1'b0, 10'h080, 16'h0000);
      wait_done(200, 1'b0, dcyc, fg, gcyc);
      check("post_rst_winner", done, 2'b01);
      check("post_rst_rd", rd_data, 16'h2468);
      req = '0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
